// File: rtl/ft_test_engine_if.sv
// RX/TX FIFO port bundle between the test engine (master) and the proto245s FIFOs (slave).
interface ft_test_engine_if #(
   parameter int DATA_W = 8
);
   logic              rxfifo_rd;
   logic [DATA_W-1:0] rxfifo_data;
   logic              rxfifo_valid;
   logic              rxfifo_empty;
   logic              txfifo_wr;
   logic [DATA_W-1:0] txfifo_data;
   logic              txfifo_full;

   modport master (
      output rxfifo_rd,
      input  rxfifo_data,
      input  rxfifo_valid,
      input  rxfifo_empty,
      output txfifo_wr,
      output txfifo_data,
      input  txfifo_full
   );

   modport slave (
      input  rxfifo_rd,
      output rxfifo_data,
      output rxfifo_valid,
      output rxfifo_empty,
      input  txfifo_wr,
      input  txfifo_data,
      output txfifo_full
   );
endinterface

// File: rtl/ft_test_engine.sv
// Command-driven FIFO traffic generator/checker: TX pattern, RX check, LED write, error-count readback.
// Optional echo command 0x100B is built only when FT_TEST_LOOPBACK_EN is defined.
module ft_test_engine #(
   parameter int DATA_W = 8,
   parameter int LED_W  = 8
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   ft_test_engine_if.master  bus,
   output logic [LED_W-1:0]  led,
   output logic              busy,
   output logic              err_flag
);
   if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32)) begin : g_bad_data_w
      $error("ft_test_engine: DATA_W must be 8, 16 or 32");
   end
   if (LED_W < 1 || LED_W > 32) begin : g_bad_led_w
      $error("ft_test_engine: LED_W must be 1..32");
   end

   localparam int WORDS = 32 / DATA_W;

   typedef enum logic [2:0] {
      CMD_WAIT, CMD_READ, CMD_PARSE, TX_RUN, RX_RUN, RX_REPLY
`ifdef FT_TEST_LOOPBACK_EN
      , LB_RUN
`endif
   } state_t;

   state_t             state_q, state_d;
   logic [63:0]        shifter_q, shifter_d;
   logic               rd_q, rd_d;
   logic               tx_req_q, tx_req_d;
   logic [DATA_W-1:0]  tx_data_q, tx_data_d;
   logic [31:0]        tx_left_q, tx_left_d;
   logic [31:0]        tx_shift_q, tx_shift_d;
   logic               tx_pat_q, tx_pat_d;
   logic [31:0]        total_q, total_d;
   logic [31:0]        issued_q, issued_d;
   logic [31:0]        recv_q, recv_d;
   logic [DATA_W-1:0]  golden_q, golden_d;
   logic [31:0]        err_cnt_q, err_cnt_d;
   logic               err_flag_q, err_flag_d;
   logic [LED_W-1:0]   led_q, led_d;

   logic [15:0] code;
   logic [31:0] arg;
   logic        known_code;
   logic        frame_ok;

   assign code = shifter_q[55:40];
   assign arg  = shifter_q[39:8];

   always_comb begin
      known_code = (code == 16'hBEEF) || (code == 16'hCAFE) ||
                   (code == 16'h1ED0) || (code == 16'h5747);
`ifdef FT_TEST_LOOPBACK_EN
      known_code = known_code || (code == 16'h100B);
`endif
   end

   assign frame_ok = (shifter_q[63:56] == 8'hAA) && (shifter_q[7:0] == 8'h55) && known_code;

   assign bus.rxfifo_rd   = rd_q;
   assign bus.txfifo_wr   = tx_req_q & ~bus.txfifo_full;
   assign bus.txfifo_data = tx_data_q;
   assign led             = led_q;
   assign err_flag        = err_flag_q;
   assign busy            = !(state_q == CMD_WAIT || state_q == CMD_READ || state_q == CMD_PARSE);

   always_comb begin
      state_d    = state_q;
      shifter_d  = shifter_q;
      rd_d       = 1'b0;
      tx_req_d   = tx_req_q;
      tx_data_d  = tx_data_q;
      tx_left_d  = tx_left_q;
      tx_shift_d = tx_shift_q;
      tx_pat_d   = tx_pat_q;
      total_d    = total_q;
      issued_d   = issued_q;
      recv_d     = recv_q;
      golden_d   = golden_q;
      err_cnt_d  = err_cnt_q;
      err_flag_d = err_flag_q;
      led_d      = led_q;
      case (state_q)
         CMD_WAIT: if (!bus.rxfifo_empty) begin
            rd_d    = 1'b1;
            state_d = CMD_READ;
         end
         CMD_READ: if (bus.rxfifo_valid) begin
            shifter_d = {bus.rxfifo_data, shifter_q[63:DATA_W]};
            state_d   = CMD_PARSE;
         end
         CMD_PARSE: begin
            state_d = CMD_WAIT;
            if (frame_ok) begin
               shifter_d = '0;
               total_d   = arg;
               issued_d  = '0;
               recv_d    = '0;
               case (code)
                  16'hBEEF: if (arg != 32'd0) begin
                     tx_req_d  = 1'b1;
                     tx_data_d = '0;
                     tx_left_d = arg - 32'd1;
                     tx_pat_d  = 1'b1;
                     state_d   = TX_RUN;
                  end
                  16'hCAFE: begin
                     err_cnt_d = '0;
                     golden_d  = '0;
                     state_d   = (arg == 32'd0) ? RX_REPLY : RX_RUN;
                  end
                  16'h1ED0: led_d = arg[LED_W-1:0];
                  16'h5747: begin
                     tx_req_d   = 1'b1;
                     tx_data_d  = err_cnt_q[DATA_W-1:0];
                     tx_shift_d = err_cnt_q >> DATA_W;
                     tx_left_d  = 32'(WORDS - 1);
                     tx_pat_d   = 1'b0;
                     state_d    = TX_RUN;
                  end
`ifdef FT_TEST_LOOPBACK_EN
                  16'h100B: if (arg != 32'd0) state_d = LB_RUN;
`endif
                  default: ;
               endcase
            end
         end
         TX_RUN: if (bus.txfifo_wr) begin
            if (tx_left_q == 32'd0) begin
               tx_req_d = 1'b0;
               state_d  = CMD_WAIT;
            end else begin
               tx_left_d = tx_left_q - 32'd1;
               if (tx_pat_q) begin
                  tx_data_d = tx_data_q + DATA_W'(1);
               end else begin
                  tx_data_d  = tx_shift_q[DATA_W-1:0];
                  tx_shift_d = tx_shift_q >> DATA_W;
               end
            end
         end
         RX_RUN: begin
            // One read in flight at a time: empty is only trusted once the previous read has landed.
            rd_d = !bus.rxfifo_empty && !rd_q && (issued_q < total_q);
            if (rd_q) issued_d = issued_q + 32'd1;
            if (bus.rxfifo_valid) begin
               if (bus.rxfifo_data != golden_q && err_cnt_q != 32'hFFFF_FFFF)
                  err_cnt_d = err_cnt_q + 32'd1;
               golden_d = golden_q + DATA_W'(1);
               recv_d   = recv_q + 32'd1;
               if (recv_q == total_q - 32'd1) state_d = RX_REPLY;
            end
         end
         RX_REPLY: begin
            tx_req_d   = 1'b1;
            tx_data_d  = (err_cnt_q != 32'd0) ? DATA_W'(8'hEE) : DATA_W'(8'h42);
            tx_left_d  = '0;
            err_flag_d = (err_cnt_q != 32'd0);
            state_d    = TX_RUN;
         end
`ifdef FT_TEST_LOOPBACK_EN
         LB_RUN: begin
            // tx_data_q doubles as the skid slot: a read is only issued while it is free.
            rd_d = !bus.rxfifo_empty && !rd_q && !bus.txfifo_full && !tx_req_q && (issued_q < total_q);
            if (rd_q) issued_d = issued_q + 32'd1;
            if (bus.rxfifo_valid) begin
               tx_req_d  = 1'b1;
               tx_data_d = bus.rxfifo_data;
               recv_d    = recv_q + 32'd1;
            end
            if (bus.txfifo_wr) begin
               tx_req_d = 1'b0;
               if (recv_q == total_q) state_d = CMD_WAIT;
            end
         end
`endif
         default: state_d = CMD_WAIT;
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q    <= CMD_WAIT;
         shifter_q  <= '0;
         rd_q       <= 1'b0;
         tx_req_q   <= 1'b0;
         tx_data_q  <= '0;
         tx_left_q  <= '0;
         tx_shift_q <= '0;
         tx_pat_q   <= 1'b0;
         total_q    <= '0;
         issued_q   <= '0;
         recv_q     <= '0;
         golden_q   <= '0;
         err_cnt_q  <= '0;
         err_flag_q <= 1'b0;
         led_q      <= '0;
      end else begin
         state_q    <= state_d;
         shifter_q  <= shifter_d;
         rd_q       <= rd_d;
         tx_req_q   <= tx_req_d;
         tx_data_q  <= tx_data_d;
         tx_left_q  <= tx_left_d;
         tx_shift_q <= tx_shift_d;
         tx_pat_q   <= tx_pat_d;
         total_q    <= total_d;
         issued_q   <= issued_d;
         recv_q     <= recv_d;
         golden_q   <= golden_d;
         err_cnt_q  <= err_cnt_d;
         err_flag_q <= err_flag_d;
         led_q      <= led_d;
      end
   end
endmodule
